// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, fill count and flush.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module fifo_sync_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 wr_error_o,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     r_data_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic                 rd_error_o,
    output logic [PTR_WIDTH:0]   count_o
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, full_d;
    logic                 afull_q, afull_d;
    logic                 empty_q, empty_d;
    logic                 aempty_q, aempty_d;
    logic                 wr_err_q, wr_err_d;
    logic                 rd_err_q, rd_err_d;
    logic                 rd_acc, wr_acc;
    logic                 mem_we;

    // A write into a full FIFO is only legal when the same cycle frees a slot.
    always_comb begin
        rd_acc   = rd_en_i & ~empty_q;
        wr_acc   = wr_en_i & (~full_q | rd_acc);
        mem_we   = wr_acc & ~flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_err_d = wr_en_i & ~wr_acc;
        rd_err_d = rd_en_i & empty_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wr_err_d = 1'b0;
            rd_err_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        end

        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AF_C);
        empty_d  = (count_d == '0);
        aempty_d = (count_d <= AE_C);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[wr_ptr_q] <= wdata_i;
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign r_data_o = mem[rd_ptr_q];
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc && !flush_i) rdata_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign r_data_o = rdata_q;
`endif

    assign full_o         = full_q;
    assign almost_full_o  = afull_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = aempty_q;
    assign wr_error_o     = wr_err_q;
    assign rd_error_o     = rd_err_q;
    assign count_o        = count_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Randomised self-checking bench for fifo_sync_prog against a queue-based reference model.
module tb_fifo_sync_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             flush_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             full_o;
    logic             almost_full_o;
    logic             wr_error_o;
    logic             rd_en_i;
    logic [WIDTH-1:0] r_data_o;
    logic             empty_o;
    logic             almost_empty_o;
    logic             rd_error_o;
    logic [PW:0]      count_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_rdata;
    bit               rdata_chk;
    bit               exp_wr_err;
    bit               exp_rd_err;

    fifo_sync_prog #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_THRESH(DEPTH - 2), .AE_THRESH(2)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wdata_i(wdata_i), .full_o(full_o),
        .almost_full_o(almost_full_o), .wr_error_o(wr_error_o),
        .rd_en_i(rd_en_i), .r_data_o(r_data_o), .empty_o(empty_o),
        .almost_empty_o(almost_empty_o), .rd_error_o(rd_error_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Applies one cycle of stimulus and advances the reference model; no checking here.
    task automatic drive_cycle(input bit wr, input bit rd, input bit fl, input logic [WIDTH-1:0] d);
        int sz;
        bit can_rd, can_wr;
        wr_en_i = wr;
        rd_en_i = rd;
        flush_i = fl;
        wdata_i = d;
        sz = model_q.size();
        if (fl) begin
            model_q.delete();
            exp_wr_err = 1'b0;
            exp_rd_err = 1'b0;
        end else begin
            can_rd     = rd && (sz > 0);
            can_wr     = wr && ((sz < DEPTH) || can_rd);
            exp_rd_err = rd && (sz == 0);
            exp_wr_err = wr && !can_wr;
            if (can_rd) exp_rdata = model_q.pop_front();
            if (can_wr) model_q.push_back(d);
        end
`ifdef FIFO_SYNC_FWFT_EN
        rdata_chk = (model_q.size() > 0);
        if (rdata_chk) exp_rdata = model_q[0];
`else
        rdata_chk = 1'b1;
`endif
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", count_o); end
        vectors++;
        if ({empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got e=%b ae=%b f=%b af=%b want 1 1 0 0", empty_o, almost_empty_o, full_o, almost_full_o);
        end
        vectors++;
        if ({wr_error_o, rd_error_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_errors: got wr=%b rd=%b want 0 0", wr_error_o, rd_error_o);
        end
`ifndef FIFO_SYNC_FWFT_EN
        vectors++;
        if (r_data_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h want 00", r_data_o); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 8'(i));
            vectors++;
            if (count_o !== 5'(i)) begin miscompares++; $display("[TB] FAIL fill_count: got %0d want %0d", count_o, i); end
            vectors++;
            if (almost_full_o !== (i >= DEPTH - 2)) begin
                miscompares++;
                $display("[TB] FAIL fill_afull: count %0d got %b want %b", i, almost_full_o, (i >= DEPTH - 2));
            end
            vectors++;
            if (wr_error_o !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_wr_err: got %b want 0", wr_error_o); end
        end
        vectors++;
        if (full_o !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b want 1", full_o); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            if (rdata_chk) begin
                vectors++;
                if (r_data_o !== exp_rdata) begin
                    miscompares++;
                    $display("[TB] FAIL drain_data: read %0d got %h want %h", i, r_data_o, exp_rdata);
                end
            end
            vectors++;
            if (almost_empty_o !== (DEPTH - i <= 2)) begin
                miscompares++;
                $display("[TB] FAIL drain_aempty: count %0d got %b want %b", DEPTH - i, almost_empty_o, (DEPTH - i <= 2));
            end
        end
`ifndef FIFO_SYNC_FWFT_EN
        vectors++;
        if (r_data_o !== 8'h10) begin miscompares++; $display("[TB] FAIL drain_last: got %h want 10", r_data_o); end
`endif
        vectors++;
        if (empty_o !== 1'b1 || count_o !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL drain_empty: got empty=%b count=%0d want 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_errors();
        // Write and read together on an empty FIFO: write wins, read is rejected.
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h3C);
        vectors++;
        if (rd_error_o !== 1'b1 || wr_error_o !== 1'b0 || count_o !== 5'd1) begin
            miscompares++;
            $display("[TB] FAIL empty_wr_rd: got rd_err=%b wr_err=%b count=%0d want 1 0 1", rd_error_o, wr_error_o, count_o);
        end
        for (int i = 1; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        drive_cycle(1'b1, 1'b0, 1'b0, 8'hAA);
        vectors++;
        if (wr_error_o !== 1'b1 || count_o !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL full_write: got wr_err=%b count=%0d want 1 16", wr_error_o, count_o);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (wr_error_o !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_err_pulse: got %b want 0", wr_error_o); end
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            if (rdata_chk) begin
                vectors++;
                if (r_data_o !== exp_rdata) begin
                    miscompares++;
                    $display("[TB] FAIL err_drain_data: read %0d got %h want %h", i, r_data_o, exp_rdata);
                end
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (rd_error_o !== 1'b1 || count_o !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL empty_read: got rd_err=%b count=%0d want 1 0", rd_error_o, count_o);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (rd_error_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_err_pulse: got %b want 0", rd_error_o); end
    endtask

    task automatic test_pass_through();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h55);
        vectors++;
        if (count_o !== 5'd16 || full_o !== 1'b1 || wr_error_o !== 1'b0 || rd_error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pass_state: got count=%0d full=%b wr_err=%b rd_err=%b want 16 1 0 0",
                     count_o, full_o, wr_error_o, rd_error_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            if (rdata_chk) begin
                vectors++;
                if (r_data_o !== exp_rdata) begin
                    miscompares++;
                    $display("[TB] FAIL pass_data: read %0d got %h want %h", i, r_data_o, exp_rdata);
                end
            end
        end
`ifndef FIFO_SYNC_FWFT_EN
        vectors++;
        if (r_data_o !== 8'h55) begin miscompares++; $display("[TB] FAIL pass_last: got %h want 55", r_data_o); end
`endif
    endtask

    task automatic test_wrap();
        int n;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
            n = model_q.size();
            vectors++;
            if (count_o !== 5'(n)) begin miscompares++; $display("[TB] FAIL wrap_count: cycle %0d got %0d want %0d", i, count_o, n); end
            vectors++;
            if ({full_o, almost_full_o, empty_o, almost_empty_o} !== {n == DEPTH, n >= DEPTH - 2, n == 0, n <= 2}) begin
                miscompares++;
                $display("[TB] FAIL wrap_flags: cycle %0d got f=%b af=%b e=%b ae=%b for count %0d",
                         i, full_o, almost_full_o, empty_o, almost_empty_o, n);
            end
            vectors++;
            if (wr_error_o !== exp_wr_err || rd_error_o !== exp_rd_err) begin
                miscompares++;
                $display("[TB] FAIL wrap_errors: cycle %0d got wr=%b rd=%b want %b %b", i, wr_error_o, rd_error_o, exp_wr_err, exp_rd_err);
            end
            if (rdata_chk) begin
                vectors++;
                if (r_data_o !== exp_rdata) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_data: cycle %0d got %h want %h", i, r_data_o, exp_rdata);
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        drive_cycle(1'b1, 1'b0, 1'b1, 8'hEE);
        vectors++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || almost_empty_o !== 1'b1 || wr_error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_state: got count=%0d empty=%b ae=%b wr_err=%b want 0 1 1 0",
                     count_o, empty_o, almost_empty_o, wr_error_o);
        end
`ifndef FIFO_SYNC_FWFT_EN
        vectors++;
        if (r_data_o !== exp_rdata) begin miscompares++; $display("[TB] FAIL flush_hold: got %h want %h", r_data_o, exp_rdata); end
`endif
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (rd_error_o !== 1'b1 || count_o !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_ignored_write: got rd_err=%b count=%0d want 1 0", rd_error_o, count_o);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        #3;
        rst_n_i = 1'b0;
        #1;
        model_q.delete();
        exp_rdata = '0;
        test_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i   = 1'b0;
        flush_i   = 1'b0;
        wr_en_i   = 1'b0;
        rd_en_i   = 1'b0;
        wdata_i   = '0;
        exp_rdata = '0;
        rdata_chk = 1'b1;
        #12;
        test_reset();
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        test_fill();
        test_drain();
        test_errors();
        test_pass_through();
        test_wrap();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
